duty_period_meter: RTL

Multi-channel duty and period meter. Each channel measures the high time, low time and full period of an asynchronous tachometer/PWM input in clock cycles. Each input is synchronised on-chip; the block rejects partial phases after reset or enable and saturates its counters on stuck inputs. It sits beside fan/PWM control logic and feeds register banks that sample results on a per-channel valid strobe.

---
 rtl/duty_period_meter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/duty_period_meter.sv
// duty_period_meter: per-channel high/low/period meter for async tach/PWM inputs.
// Partial phases after reset or enable are discarded; phase counters saturate.
module duty_period_meter #(
    parameter int CH_NUM      = 4,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        CLK_I,
    input  logic                        RST_I,
    input  logic                        EN_I,
    input  logic [CH_NUM-1:0]           TAC_I,
    output logic [CH_NUM*CNT_W-1:0]     HIGH_CLK_NUM_O,
    output logic [CH_NUM*CNT_W-1:0]     LOW_CLK_NUM_O,
    output logic [CH_NUM*(CNT_W+1)-1:0] PERIOD_CLK_NUM_O,
    output logic [CH_NUM-1:0]           VALID_O,
    output logic [CH_NUM-1:0]           STUCK_O
);
    localparam logic [1:0] ST_PRIME = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LOW   = 2'd3;

    localparam int              PW         = $clog2(SYNC_STAGES + 1);
    localparam logic [PW-1:0]   PRIME_LAST = PW'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [SYNC_STAGES-1:0][CH_NUM-1:0] sync_q;
    logic [CH_NUM-1:0] s;
    logic [CH_NUM-1:0] s_d;
    logic [CH_NUM-1:0] rise;
    logic [CH_NUM-1:0] fall;
    logic [PW-1:0]     prime_cnt;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sync_q <= '0;
            s_d    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], TAC_I};
            s_d    <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // Shared flush timer: channels leave PRIME once the synchroniser holds real samples.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            prime_cnt <= '0;
        end else if (prime_cnt != PRIME_LAST) begin
            prime_cnt <= prime_cnt + PW'(1);
        end
    end

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        logic [1:0]       state;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_inc;
        logic [CNT_W-1:0] high_r;
        logic [CNT_W-1:0] low_r;
        logic [CNT_W:0]   per_r;
        logic             hv;
        logic             valid_r;
        logic             stuck_r;

        assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

        always_ff @(posedge CLK_I or posedge RST_I) begin
            if (RST_I) begin
                state   <= ST_PRIME;
                cnt     <= '0;
                high_r  <= '0;
                low_r   <= '0;
                per_r   <= '0;
                hv      <= 1'b0;
                valid_r <= 1'b0;
                stuck_r <= 1'b0;
            end else if (!EN_I) begin
                state   <= ST_ARM;
                cnt     <= '0;
                hv      <= 1'b0;
                valid_r <= 1'b0;
                stuck_r <= 1'b0;
            end else begin
                valid_r <= 1'b0;
                stuck_r <= 1'b0;
                case (state)
                    ST_PRIME: begin
                        if (prime_cnt == PRIME_LAST) state <= ST_ARM;
                    end
                    ST_ARM: begin
                        hv <= 1'b0;
                        if (rise[n]) begin
                            state <= ST_HIGH;
                            cnt   <= CNT_ONE;
                        end else if (fall[n]) begin
                            state <= ST_LOW;
                            cnt   <= CNT_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (fall[n]) begin
                            high_r <= cnt;
                            hv     <= 1'b1;
                            cnt    <= CNT_ONE;
                            state  <= ST_LOW;
                        end else begin
                            cnt     <= cnt_inc;
                            stuck_r <= (cnt_inc == CNT_MAX);
                        end
                    end
                    ST_LOW: begin
                        if (rise[n]) begin
                            low_r <= cnt;
                            cnt   <= CNT_ONE;
                            state <= ST_HIGH;
                            // Period only when this low closes a high seen in the same run.
                            if (hv) begin
                                per_r   <= {1'b0, high_r} + {1'b0, cnt};
                                valid_r <= 1'b1;
                            end
                        end else begin
                            cnt     <= cnt_inc;
                            stuck_r <= (cnt_inc == CNT_MAX);
                        end
                    end
                endcase
            end
        end

        assign HIGH_CLK_NUM_O[n*CNT_W +: CNT_W]         = high_r;
        assign LOW_CLK_NUM_O[n*CNT_W +: CNT_W]          = low_r;
        assign PERIOD_CLK_NUM_O[n*(CNT_W+1) +: CNT_W+1] = per_r;
        assign VALID_O[n]                               = valid_r;
        assign STUCK_O[n]                               = stuck_r;
    end

endmodule
